// File: rtl/fetch_unit.sv
// Instruction fetch: IDLE/REQ/VALID sequencer with PC selection (redirect, jump, branch, sequential).
// Optional FETCH_MISALIGN_CHK_EN adds misalign_err and a HALT state for misaligned PCs.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    input  logic        stall,
    input  logic        branch,
    input  logic        zero,
    input  logic        jump,
    input  logic [31:0] branch_offset,
    input  logic        pc_load,
    input  logic [31:0] pc_load_addr
`ifdef FETCH_MISALIGN_CHK_EN
    ,
    output logic        misalign_err
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_VALID = 2'd2
`ifdef FETCH_MISALIGN_CHK_EN
        ,
        ST_HALT  = 2'd3
`endif
    } state_t;

    state_t      state_r;
    state_t      state_sel_s;
    state_t      state_next_s;
    logic [31:0] pc_r;
    logic [31:0] pc_plus4_r;
    logic [31:0] instr_r;
    logic        imem_req_r;
    logic        instr_valid_r;
    logic [31:0] pc_next_s;
    logic [31:0] instr_next_s;
    logic [31:0] target_s;

    // With the checker disabled every loaded PC is word-aligned by dropping the low bits;
    // with it enabled the value is kept so the misalignment can be detected.
    function automatic logic [31:0] fix_pc(input logic [31:0] a);
`ifdef FETCH_MISALIGN_CHK_EN
        return a;
`else
        return {a[31:2], 2'b00};
`endif
    endfunction

    function automatic logic is_misaligned(input logic [31:0] a);
        return (a[1:0] != 2'b00);
    endfunction

    // Next-PC priority select, then state/pc/instr next values.
    always_comb begin
        state_sel_s  = state_r;
        pc_next_s    = pc_r;
        instr_next_s = instr_r;
        target_s     = pc_plus4_r;

        if (pc_load) begin
            target_s = pc_load_addr;
        end else if (jump) begin
            target_s = {pc_plus4_r[31:28], instr_r[25:0], 2'b00};
        end else if (branch && zero) begin
            target_s = pc_plus4_r + (branch_offset << 2);
        end else begin
            target_s = pc_plus4_r;
        end

        case (state_r)
            ST_IDLE: begin
                if (pc_load) begin
                    pc_next_s   = fix_pc(pc_load_addr);
                    state_sel_s = ST_IDLE;
                end else begin
                    state_sel_s = ST_REQ;
                end
            end
            ST_REQ: begin
                // A redirect drops any ack of this cycle and inserts one idle cycle.
                if (pc_load) begin
                    pc_next_s   = fix_pc(pc_load_addr);
                    state_sel_s = ST_IDLE;
                end else if (imem_ack) begin
                    instr_next_s = imem_rdata;
                    state_sel_s  = ST_VALID;
                end else begin
                    state_sel_s = ST_REQ;
                end
            end
            ST_VALID: begin
                if (stall) begin
                    state_sel_s = ST_VALID;
                end else begin
                    pc_next_s   = fix_pc(target_s);
                    state_sel_s = ST_REQ;
                end
            end
`ifdef FETCH_MISALIGN_CHK_EN
            ST_HALT: begin
                state_sel_s = ST_HALT;
            end
`endif
            default: begin
                state_sel_s = ST_IDLE;
            end
        endcase

`ifdef FETCH_MISALIGN_CHK_EN
        state_next_s = is_misaligned(pc_next_s) ? ST_HALT : state_sel_s;
`else
        state_next_s = state_sel_s;
`endif
    end

    // State, PC and instruction registers; outputs are registered from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            pc_r          <= fix_pc(RESET_PC);
            pc_plus4_r    <= fix_pc(RESET_PC) + 32'd4;
            instr_r       <= 32'h0000_0000;
            imem_req_r    <= 1'b0;
            instr_valid_r <= 1'b0;
        end else begin
            state_r       <= state_next_s;
            pc_r          <= pc_next_s;
            pc_plus4_r    <= pc_next_s + 32'd4;
            instr_r       <= instr_next_s;
            imem_req_r    <= (state_next_s == ST_REQ);
            instr_valid_r <= (state_next_s == ST_VALID);
        end
    end

`ifdef FETCH_MISALIGN_CHK_EN
    logic misalign_err_r;

    // Sticky error flag, mirrors residence in HALT.
    always_ff @(posedge clk) begin
        if (rst) begin
            misalign_err_r <= 1'b0;
        end else begin
            misalign_err_r <= (state_next_s == ST_HALT);
        end
    end

    assign misalign_err = misalign_err_r;
`endif

    assign imem_req    = imem_req_r;
    assign imem_addr   = pc_r;
    assign instr       = instr_r;
    assign instr_valid = instr_valid_r;
    assign pc          = pc_r;
    assign pc_plus4    = pc_plus4_r;

endmodule
